// File: rtl/qam16_rx_checker_pkg.sv
// Shared types, constants and the QAM-16 axis slicer for the RX checker slice.
package qam16_rx_checker_pkg;

  typedef logic [3:0] qam_bits_t;

  localparam int PRBS23_LEN = 23;
  localparam int PRBS23_TAP = 18;
  localparam int QAM_LVL_A  = 256;
  localparam int QAM_SPS    = 4;

  // Gray-coded decision for one axis: -3A->00, -A->01, +A->11, +3A->10.
  // Inputs are sign-extended to 32 bits, so the -2A compare can never overflow.
  function automatic logic [1:0] qam16_slice_axis(input logic signed [31:0] x,
                                                  input logic signed [31:0] a);
    logic [1:0] b;
    if (x < -(a <<< 1))     b = 2'b00;
    else if (x < 0)         b = 2'b01;
    else if (x < (a <<< 1)) b = 2'b11;
    else                    b = 2'b10;
    return b;
  endfunction

endpackage

// File: rtl/qam16_rx_checker_prbs23_checker.sv
// Self-synchronising PRBS-23 (x^23 + x^18 + 1) checker, four bits per strobe.
// SEARCH loads received bits straight into the LFSR; LOCKED free-runs and
// counts bit errors, dropping back to SEARCH when a window sees too many.
module prbs23_checker
  import qam16_rx_checker_pkg::*;
#(
  parameter int WIN_SYMS = 64,
  parameter int LOSS_THR = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr_counts,
  input  logic [3:0]  sym_bits,
  input  logic        sym_valid,
  output logic        locked,
  output logic [31:0] bit_count,
  output logic [31:0] err_count
);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int FILL_SYMS = (PRBS23_LEN + 3) / 4;
  localparam int WIN_W     = $clog2(WIN_SYMS) + 1;
  localparam logic [31:0] CNT_MAX = '1;

  logic [0:0]            state_q, state_d;
  logic [PRBS23_LEN-1:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [2:0]            fill_q, fill_d;
  logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
  logic [15:0]           win_err_q, win_err_d, win_err_sum;
  logic [31:0]           bit_count_q, bit_count_d;
  logic [31:0]           err_count_q, err_count_d;
  logic [2:0]            nerr;
  logic                  fb;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? CNT_MAX : s[31:0];
  endfunction

  // Unrolled 4-bit LFSR step, FSM, loss-of-lock window and saturating counters.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    fill_d      = fill_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    lfsr_nxt    = lfsr_q;
    nerr        = '0;
    fb          = 1'b0;
    // MSB of the symbol is the oldest bit on the wire.
    for (int k = 3; k >= 0; k--) begin
      fb = lfsr_nxt[PRBS23_LEN-1] ^ lfsr_nxt[PRBS23_TAP-1];
      if (state_q == ST_LOCKED) begin
        nerr     = nerr + {2'b00, fb ^ sym_bits[k]};
        lfsr_nxt = {lfsr_nxt[PRBS23_LEN-2:0], fb};
      end else begin
        lfsr_nxt = {lfsr_nxt[PRBS23_LEN-2:0], sym_bits[k]};
      end
    end
    win_err_sum = win_err_q + {13'd0, nerr};

    if (en && sym_valid) begin
      lfsr_d = lfsr_nxt;
      if (state_q == ST_SEARCH) begin
        if (fill_q == 3'(FILL_SYMS - 1)) begin
          fill_d = '0;
          // An all-zero register would stick forever, so refill instead.
          if (lfsr_nxt != '0) begin
            state_d   = ST_LOCKED;
            win_cnt_d = '0;
            win_err_d = '0;
          end
        end else begin
          fill_d = fill_q + 3'd1;
        end
      end else begin
        // err_count freezes together with a saturated bit_count.
        if (bit_count_q != CNT_MAX) begin
          bit_count_d = sat_add32(bit_count_q, 32'd4);
          err_count_d = sat_add32(err_count_q, {29'd0, nerr});
        end
        if (win_err_sum >= 16'(LOSS_THR)) begin
          state_d   = ST_SEARCH;
          fill_d    = '0;
          win_cnt_d = '0;
          win_err_d = '0;
        end else if (win_cnt_q == WIN_W'(WIN_SYMS - 1)) begin
          win_cnt_d = '0;
          win_err_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
          win_err_d = win_err_sum;
        end
      end
    end

    if (clr_counts) begin
      bit_count_d = '0;
      err_count_d = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      lfsr_q      <= '0;
      fill_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      fill_q      <= fill_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign bit_count = bit_count_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/qam16_rx_checker.sv
// QAM-16 receive checker: decimates matched-filtered I/Q by SPS at a
// programmable phase, slices to Gray bits and feeds a PRBS-23 BER checker.
// Optional macro RX_EVM_EN adds evm_acc, a saturating sum of |x - ideal|.
module qam16_rx_checker
  import qam16_rx_checker_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int SPS      = QAM_SPS,
  parameter int LVL_A    = QAM_LVL_A,
  parameter int WIN_SYMS = 64,
  parameter int LOSS_THR = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr_counts,
  input  logic [DATA_W-1:0]       rx_I,
  input  logic [DATA_W-1:0]       rx_Q,
  input  logic                    rx_valid,
  input  logic [$clog2(SPS)-1:0]  sym_phase,
  output logic [3:0]              sym_bits,
  output logic                    sym_valid,
  output logic                    locked,
  output logic [31:0]             bit_count,
  output logic [31:0]             err_count
`ifdef RX_EVM_EN
  ,
  output logic [31:0]             evm_acc
`endif
);

  localparam int PH_W = $clog2(SPS);

  logic [PH_W-1:0]    ph_q, ph_d;
  qam_bits_t          sym_bits_q, sym_bits_d;
  logic               sym_valid_q, sym_valid_d;
  logic               take;
  logic signed [31:0] x_i, x_q;

  assign x_i  = 32'($signed(rx_I));
  assign x_q  = 32'($signed(rx_Q));
  assign take = en && rx_valid && (ph_q == sym_phase);

  // Phase counter and symbol decision on the selected sample.
  always_comb begin
    ph_d        = ph_q;
    sym_bits_d  = sym_bits_q;
    sym_valid_d = 1'b0;
    if (en && rx_valid) begin
      ph_d = (ph_q == PH_W'(SPS - 1)) ? '0 : ph_q + 1'b1;
    end
    if (take) begin
      sym_bits_d  = {qam16_slice_axis(x_i, LVL_A), qam16_slice_axis(x_q, LVL_A)};
      sym_valid_d = 1'b1;
    end
  end

  // Decimator/slicer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q        <= '0;
      sym_bits_q  <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      sym_bits_q  <= sym_bits_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  // A strobe registered just before en drops is suppressed, not delivered late.
  assign sym_bits  = sym_bits_q;
  assign sym_valid = sym_valid_q & en;

  prbs23_checker #(
    .WIN_SYMS (WIN_SYMS),
    .LOSS_THR (LOSS_THR)
  ) u_prbs23_checker (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr_counts (clr_counts),
    .sym_bits   (sym_bits),
    .sym_valid  (sym_valid),
    .locked     (locked),
    .bit_count  (bit_count),
    .err_count  (err_count)
  );

`ifdef RX_EVM_EN
  logic [31:0] evm_acc_q, evm_acc_d;

  function automatic logic [31:0] axis_err(input logic signed [31:0] x, input logic [1:0] b);
    logic signed [31:0] ideal, diff;
    case (b)
      2'b00:   ideal = -3 * LVL_A;
      2'b01:   ideal = -LVL_A;
      2'b11:   ideal = LVL_A;
      default: ideal = 3 * LVL_A;
    endcase
    diff = x - ideal;
    return (diff < 0) ? -diff : diff;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Error-vector magnitude accumulation on each decided symbol.
  always_comb begin
    evm_acc_d = evm_acc_q;
    if (take) begin
      evm_acc_d = sat_add32(sat_add32(evm_acc_q, axis_err(x_i, sym_bits_d[3:2])),
                            axis_err(x_q, sym_bits_d[1:0]));
    end
    if (clr_counts) evm_acc_d = '0;
  end

  // EVM accumulator register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) evm_acc_q <= '0;
    else     evm_acc_q <= evm_acc_d;
  end

  assign evm_acc = evm_acc_q;
`endif

endmodule

// File: tb/tb_qam16_rx_checker.sv
// Randomised self-checking bench for qam16_rx_checker with a sequence-level
// reference model of the slicer and the PRBS-23 lock/BER behaviour.
module tb_qam16_rx_checker;

  localparam int SPS      = 4;
  localparam int A        = 256;
  localparam int WIN_SYMS = 64;
  localparam int LOSS_THR = 16;

  logic        clk = 1'b0;
  logic        rst, en, clr_counts, rx_valid;
  logic [11:0] rx_I, rx_Q;
  logic [1:0]  sym_phase;
  logic [3:0]  sym_bits;
  logic        sym_valid, locked;
  logic [31:0] bit_count, err_count;
`ifdef RX_EVM_EN
  logic [31:0] evm_acc;
`endif

  qam16_rx_checker dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr_counts (clr_counts),
    .rx_I       (rx_I),
    .rx_Q       (rx_Q),
    .rx_valid   (rx_valid),
    .sym_phase  (sym_phase),
    .sym_bits   (sym_bits),
    .sym_valid  (sym_valid),
    .locked     (locked),
    .bit_count  (bit_count),
    .err_count  (err_count)
`ifdef RX_EVM_EN
    ,
    .evm_acc    (evm_acc)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [3:0] exp_q[$];
  bit         ref_q[$];   // last 23 reference bits, index 0 oldest
  bit         gs[$];      // transmitter PRBS state, index 0 oldest
  int m_locked, m_fill, m_win, m_werr, m_bits, m_errs;

  function automatic logic [1:0] slice_ref(input int x);
    if (x < -2 * A)     return 2'b00;
    else if (x < 0)     return 2'b01;
    else if (x < 2 * A) return 2'b11;
    else                return 2'b10;
  endfunction

  function automatic int lvl(input logic [1:0] b);
    case (b)
      2'b00:   return -3 * A;
      2'b01:   return -A;
      2'b11:   return A;
      default: return 3 * A;
    endcase
  endfunction

  task automatic model_reset();
    m_locked = 0; m_fill = 0; m_win = 0; m_werr = 0; m_bits = 0; m_errs = 0;
    ref_q.delete();
  endtask

  task automatic model_sym(input logic [3:0] b);
    int e;
    bit nb, any;
    if (m_locked == 0) begin
      for (int k = 3; k >= 0; k--) begin
        ref_q.push_back(b[k]);
        if (ref_q.size() > 23) void'(ref_q.pop_front());
      end
      m_fill++;
      if (m_fill == 6) begin
        m_fill = 0;
        any = 0;
        foreach (ref_q[i]) any |= ref_q[i];
        if (any) begin m_locked = 1; m_win = 0; m_werr = 0; end
      end
    end else begin
      e = 0;
      for (int k = 3; k >= 0; k--) begin
        nb = ref_q[0] ^ ref_q[5];
        void'(ref_q.pop_front());
        ref_q.push_back(nb);
        if (nb != b[k]) e++;
      end
      m_bits += 4; m_errs += e; m_werr += e;
      if (m_werr >= LOSS_THR) begin m_locked = 0; m_fill = 0; end
      else if (m_win == WIN_SYMS - 1) begin m_win = 0; m_werr = 0; end
      else m_win++;
    end
  endtask

  function automatic bit gen_bit();
    bit nb;
    nb = gs[0] ^ gs[5];
    void'(gs.pop_front());
    gs.push_back(nb);
    return nb;
  endfunction

  function automatic logic [3:0] next_prbs_sym();
    logic [3:0] b;
    for (int k = 3; k >= 0; k--) b[k] = gen_bit();
    return b;
  endfunction

  // ---------------- monitor ----------------
  logic [3:0] mon_bits;
  bit         pend = 0;
  bit         watch_unlock = 0, saw_unlock = 0;

  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        check("locked", 32'(locked), 32'(m_locked));
        check("bit_count", bit_count, m_bits);
        check("err_count", err_count, m_errs);
        pend = 0;
      end
      if (sym_valid) begin
        if (exp_q.size() == 0) begin
          check("sym_valid_unexpected", 32'(sym_valid), 32'd0);
        end else begin
          mon_bits = exp_q.pop_front();
          check("sym_bits", 32'(sym_bits), 32'(mon_bits));
          model_sym(mon_bits);
          pend = 1;
        end
      end
      if (watch_unlock && !locked) saw_unlock = 1;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int i, input int q, input logic v);
    @(posedge clk);
    #1;
    rx_I = i[11:0];
    rx_Q = q[11:0];
    rx_valid = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0);
  endtask

  function automatic int junk();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic send_raw(input int i, input int q);
    for (int k = 0; k < SPS; k++) begin
      if ($urandom_range(0, 3) == 0) drive(0, 0, 1'b0);
      if (k == int'(sym_phase)) begin
        exp_q.push_back({slice_ref(i), slice_ref(q)});
        drive(i, q, 1'b1);
      end else begin
        drive(junk(), junk(), 1'b1);
      end
    end
  endtask

  task automatic send_sym(input logic [3:0] b);
    send_raw(lvl(b[3:2]) + int'($urandom_range(0, 511)) - 256,
             lvl(b[1:0]) + int'($urandom_range(0, 511)) - 256);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    model_reset();
    idle(2);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_clr();
    idle(2);
    @(posedge clk);
    #1 clr_counts = 1'b1;
    @(posedge clk);
    #1 clr_counts = 1'b0;
    m_bits = 0;
    m_errs = 0;
    @(negedge clk);
    check("clr_bit_count", bit_count, 32'd0);
    check("clr_err_count", err_count, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int         th[7] = '{0, 511, 512, -512, -513, -2048, 2047};
  logic [3:0] masks[7] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'hF};
  logic [3:0] b;

  initial begin
    rst = 1'b1; en = 1'b1; clr_counts = 1'b0;
    rx_I = '0; rx_Q = '0; rx_valid = 1'b0; sym_phase = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sym_bits", 32'(sym_bits), 32'd0);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_bit_count", bit_count, 32'd0);
    check("rst_err_count", err_count, 32'd0);
`ifdef RX_EVM_EN
    check("rst_evm_acc", evm_acc, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Ideal (+3A,-A) at phase 0, then three ignored samples.
    exp_q.push_back(4'b1001);
    drive(768, -256, 1'b1);
    drive(0, 0, 1'b0);
    @(negedge clk);
    check("latency_sym_valid", 32'(sym_valid), 32'd1);
    check("latency_sym_bits", 32'(sym_bits), 32'b1001);
    drive(0, 0, 1'b0);
    @(negedge clk);
    check("strobe_width", 32'(sym_valid), 32'd0);
    drive(-768, 768, 1'b1);
    drive(256, 256, 1'b1);
    drive(-2048, 2047, 1'b1);
    idle(1);

    // Decision thresholds at random phases.
    foreach (th[i]) begin
      sym_phase = 2'($urandom_range(0, 3));
      send_raw(th[i], 0);
    end
    idle(3);

    // All-zero fill must not lock.
    do_reset();
    for (int i = 0; i < 7; i++) send_sym(4'b0000);
    idle(3);
    @(negedge clk);
    check("all_zero_no_lock", 32'(locked), 32'd0);

    // Clean PRBS-23 from seed 0x7FFFFF.
    do_reset();
    gs.delete();
    repeat (23) gs.push_back(1'b1);
    sym_phase = 2'($urandom_range(0, 3));
    for (int i = 0; i < 200; i++) begin
      send_sym(next_prbs_sym());
      if (i == 4 || i == 5) begin
        idle(2);
        @(negedge clk);
        check("lock_after_6", 32'(locked), (i == 5) ? 32'd1 : 32'd0);
      end
      if (i == 50) begin
        idle(2);
        en = 1'b0;
        drive(junk(), junk(), 1'b1);
        drive(junk(), junk(), 1'b1);
        drive(junk(), junk(), 1'b1);
        drive(0, 0, 1'b0);
        en = 1'b1;
      end
    end
    idle(3);
    @(negedge clk);
    check("clean_bit_count", bit_count, 32'd776);
    check("clean_err_count", err_count, 32'd0);
    check("clean_locked", 32'(locked), 32'd1);

    // Single flipped bit in symbol 100.
    pulse_clr();
    sym_phase = 2'($urandom_range(0, 3));
    for (int i = 0; i < 120; i++) begin
      b = next_prbs_sym();
      if (i == 99) b[$urandom_range(0, 3)] ^= 1'b1;
      send_sym(b);
    end
    idle(3);
    @(negedge clk);
    check("flip_err_count", err_count, 32'd1);
    check("flip_bit_count", bit_count, 32'd480);
    check("flip_locked", 32'(locked), 32'd1);

    // Burst of corrupted symbols, then clean data again.
    saw_unlock = 0;
    watch_unlock = 1;
    for (int i = 0; i < 20; i++) send_sym(next_prbs_sym() ^ masks[$urandom_range(0, 6)]);
    idle(3);
    watch_unlock = 0;
    @(negedge clk);
    check("burst_unlock", 32'(saw_unlock), 32'd1);
    check("counts_retained", 32'(err_count >= 32'd16), 32'd1);
    sym_phase = 2'($urandom_range(0, 3));
    for (int i = 0; i < 60; i++) send_sym(next_prbs_sym());
    idle(3);
    @(negedge clk);
    check("relock", 32'(locked), 32'd1);
    pulse_clr();
    check("clr_keeps_lock", 32'(locked), 32'd1);

`ifdef RX_EVM_EN
    send_raw(3 * A + 5, A - 3);
    idle(3);
    @(negedge clk);
    check("evm_acc", evm_acc, 32'd8);
`endif

    // Asynchronous reset while a strobe is high.
    idle(2);
    sym_phase = 2'd0;
    exp_q.push_back(4'b1001);
    drive(768, -256, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check("arst_sym_valid", 32'(sym_valid), 32'd0);
    check("arst_sym_bits", 32'(sym_bits), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_bit_count", bit_count, 32'd0);
    check("arst_err_count", err_count, 32'd0);
`ifdef RX_EVM_EN
    check("arst_evm_acc", evm_acc, 32'd0);
`endif
    rx_valid = 1'b0;
    idle(2);
    @(posedge clk);
    #1 rst = 1'b0;
    sym_phase = 2'($urandom_range(0, 3));
    for (int i = 0; i < 10; i++) send_sym(next_prbs_sym());
    idle(3);
    @(negedge clk);
    check("post_rst_locked", 32'(locked), 32'd1);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
